// File: rtl/activation_pkg.sv
// Shared definitions for the activation lookup initiator: FSM encoding, function
// select codes and the fixed-point formats of the sum and activation value.
package activation_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_POLL   = 3'd3;
   localparam logic [2:0] ST_OUT    = 3'd4;

   localparam logic FUNC_SIGMOID = 1'b0;
   localparam logic FUNC_TANH    = 1'b1;

   // Neuron sums are Q5.11, activation values are Q2.14.
   localparam int SUM_FRAC_BITS = 11;
   localparam int ACT_FRAC_BITS = 14;

endpackage

// File: rtl/act_req_fifo.sv
// Request buffer between the accumulators and the lookup FSM: a synchronous
// power-of-two FIFO of {func, sum} entries with full/empty flags.
module act_req_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/activation_request_sequencer.sv
// Issues buffered neuron sums to the tag-check activation unit one at a time and returns
// results in order on a valid/ready stream. Define ACT_TIMEOUT_EN to abort stuck lookups.
module activation_request_sequencer
   import activation_pkg::*;
#(
   parameter int DATAWIDTH      = 16,
   parameter int FIFO_DEPTH     = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_sum,
   input  logic                 in_func,
   output logic [DATAWIDTH-1:0] act_sum,
   output logic                 act_func,
   input  logic [DATAWIDTH-1:0] act_value,
   input  logic [DATAWIDTH-1:0] act_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_value,
   output logic [DATAWIDTH-1:0] out_sum,
   output logic                 out_err,
   output logic                 busy
);

   localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef ACT_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

   logic [2:0]         state;
   logic [CW-1:0]      cnt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [DATAWIDTH:0] fifo_head;

   act_req_fifo #(
      .WIDTH (DATAWIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (in_valid && in_ready),
      .push_data ({in_func, in_sum}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign fifo_pop = (state == ST_ISSUE);
   assign busy     = !fifo_empty || (state != ST_IDLE);

`ifdef ACT_TIMEOUT_EN
   logic err_q;
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   // ISSUE is only entered with a non-empty FIFO, so the pop there always takes the head.
   // The same counter times the settle window and, when enabled, the poll timeout.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         act_sum   <= '0;
         act_func  <= FUNC_SIGMOID;
         out_valid <= 1'b0;
         out_value <= '0;
         out_sum   <= '0;
`ifdef ACT_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               act_sum  <= fifo_head[DATAWIDTH-1:0];
               act_func <= fifo_head[DATAWIDTH];
               cnt      <= '0;
               state    <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt   <= '0;
                  state <= ST_POLL;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_POLL: begin
               if (act_tag != '0) begin
                  out_value <= act_value;
                  out_sum   <= act_sum;
                  out_valid <= 1'b1;
`ifdef ACT_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  state     <= ST_OUT;
               end
`ifdef ACT_TIMEOUT_EN
               else if (cnt == TIMEOUT_LAST) begin
                  out_value <= '0;
                  out_sum   <= act_sum;
                  out_valid <= 1'b1;
                  err_q     <= 1'b1;
                  state     <= ST_OUT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
`endif
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= fifo_empty ? ST_IDLE : ST_ISSUE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_activation_request_sequencer.sv
// Self-checking bench: a behavioural activation unit (tag N cycles after the request changes)
// plus an in-order scoreboard of accepted requests.
module tb_activation_request_sequencer;
   import activation_pkg::*;

   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_func = 1'b0, out_ready = 1'b0;
   logic [15:0] in_sum = '0;
   logic        in_ready, act_func, out_valid, out_err, busy;
   logic [15:0] act_sum, act_value, act_tag, out_value, out_sum;

   int checks = 0;
   int errors = 0;

   typedef struct packed {logic [15:0] sum; logic func;} req_t;
   typedef struct packed {logic [15:0] value; logic [15:0] sum; logic err;} res_t;
   req_t exp_q[$];
   res_t obs_q[$];

   always #5 clock = ~clock;

   activation_request_sequencer #(
      .DATAWIDTH(16), .FIFO_DEPTH(4), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_func(in_func),
      .act_sum(act_sum), .act_func(act_func), .act_value(act_value), .act_tag(act_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_sum(out_sum), .out_err(out_err), .busy(busy)
   );

   // Activation unit model: the value depends only on the presented request.
   function automatic logic [15:0] unit_value(input logic [15:0] s, input logic f);
      if (s == 16'h0800) return f ? 16'h30BE : 16'h2ECA;
      return {s[7:0], s[15:8]} ^ (f ? 16'hA5A5 : 16'h1111);
   endfunction

   int          tag_delay = 2;
   bit          tag_enable = 1'b1;
   int          since_change = 1000;
   logic [16:0] last_req = '0;

   always @(posedge clock) begin
      if ({act_func, act_sum} != last_req) since_change <= 0;
      else if (since_change < 1000) since_change <= since_change + 1;
      last_req <= {act_func, act_sum};
   end

   assign act_value = unit_value(act_sum, act_func);
   assign act_tag   = (tag_enable && since_change >= tag_delay) ? 16'd1 : 16'd0;

   always @(posedge clock) begin
      if (!reset && out_valid && out_ready) obs_q.push_back({out_value, out_sum, out_err});
   end

   // One clock of stimulus, entered and left at a falling edge.
   task automatic step(input bit v, input logic [15:0] s, input bit f, input bit r, output bit acc);
      in_valid = v; in_sum = s; in_func = f; out_ready = r;
      acc = v && in_ready;
      @(posedge clock);
      if (acc) exp_q.push_back('{sum: s, func: f});
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clock);
      exp_q.delete(); obs_q.delete();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if ({out_valid, out_err, busy, act_func, act_sum, out_value, out_sum} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got valid=%b err=%b busy=%b func=%b sum=%h val=%h osum=%h want all 0",
                  out_valid, out_err, busy, act_func, act_sum, out_value, out_sum);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single(input logic [15:0] s, input bit f, input int n, input logic [15:0] want);
      int lat, want_lat;
      bit acc;
      tag_enable = 1'b1; tag_delay = n;
      want_lat = (3 + SETTLE > 4 + n) ? 3 + SETTLE : 4 + n;
      exp_q.delete(); obs_q.delete();
      step(1'b1, s, f, 1'b1, acc);
      lat = 0;
      while (!out_valid && lat < 200) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, acc);
         lat++;
      end
      checks++;
      if (lat != want_lat) begin
         errors++; $display("[TB] FAIL single_latency sum=%h got %0d want %0d", s, lat, want_lat);
      end
      checks++;
      if ({out_valid, out_value, out_sum, out_err} !== {1'b1, want, s, 1'b0}) begin
         errors++;
         $display("[TB] FAIL single_result got v=%b val=%h sum=%h err=%b want v=1 val=%h sum=%h err=0",
                  out_valid, out_value, out_sum, out_err, want, s);
      end
      checks++;
      if ({act_func, act_sum} !== {f, s}) begin
         errors++; $display("[TB] FAIL single_act_hold got func=%b sum=%h want func=%b sum=%h", act_func, act_sum, f, s);
      end
      repeat (4) step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      checks++;
      if (obs_q.size() != 1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_count got results=%0d valid=%b busy=%b want 1 0 0", obs_q.size(), out_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] items [6];
      bit fn [6];
      int k = 0, cyc = 0;
      bit acc;
      res_t o; req_t e;
      exp_q.delete(); obs_q.delete();
      tag_enable = 1'b1; tag_delay = $urandom_range(0, 6);
      for (int i = 0; i < 6; i++) begin
         items[i] = 16'($urandom); fn[i] = 1'($urandom_range(0, 1));
      end
      while (cyc < 40) begin
         step(1'b1, items[k], fn[k], 1'b0, acc);
         if (acc && k < 5) k++;
         cyc++;
      end
      checks++;
      if (k != 5 || in_ready !== 1'b0 || out_valid !== 1'b1 || obs_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL b2b_fill got accepted=%0d in_ready=%b out_valid=%b results=%0d want 5 0 1 0",
                  k, in_ready, out_valid, obs_q.size());
      end
      cyc = 0;
      while (obs_q.size() < 5 && cyc < 400) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, acc);
         cyc++;
      end
      repeat (10) step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      checks++;
      if (obs_q.size() != 5 || exp_q.size() != 5) begin
         errors++; $display("[TB] FAIL b2b_count got %0d results want 5", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== {unit_value(e.sum, e.func), e.sum, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_order got val=%h sum=%h err=%b want val=%h sum=%h err=0",
                     o.value, o.sum, o.err, unit_value(e.sum, e.func), e.sum);
         end
      end
   endtask

   task automatic test_stream(input int n_req, input bit toggle_ready);
      int sent = 0, cyc = 0;
      bit acc, r, v, stall;
      logic [32:0] snap;
      logic [15:0] s;
      bit f;
      res_t o; req_t e;
      exp_q.delete(); obs_q.delete();
      tag_enable = 1'b1; tag_delay = $urandom_range(0, 7);
      s = 16'($urandom); f = 1'($urandom_range(0, 1));
      while ((sent < n_req || obs_q.size() < n_req) && cyc < 4000) begin
         r = toggle_ready ? cyc[0] : ($urandom_range(0, 9) < 7);
         v = (sent < n_req) && (toggle_ready || $urandom_range(0, 3) != 0);
         if (!toggle_ready) tag_delay = $urandom_range(0, 7);
         stall = out_valid && !r;
         snap  = {out_value, out_sum, out_err};
         step(v, s, f, r, acc);
         if (acc) begin
            sent++; s = 16'($urandom); f = 1'($urandom_range(0, 1));
         end
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || {out_value, out_sum, out_err} !== snap) begin
               errors++;
               $display("[TB] FAIL stall_hold got v=%b payload=%h want v=1 payload=%h",
                        out_valid, {out_value, out_sum, out_err}, snap);
            end
         end
         cyc++;
      end
      checks++;
      if (obs_q.size() != n_req || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL stream_count got %0d busy=%b want %0d busy=0", obs_q.size(), busy, n_req);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (o !== {unit_value(e.sum, e.func), e.sum, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stream_result got val=%h sum=%h err=%b want val=%h sum=%h err=0",
                     o.value, o.sum, o.err, unit_value(e.sum, e.func), e.sum);
         end
      end
   endtask

   task automatic test_timeout();
      bit acc;
      int cyc = 0;
      res_t o;
      exp_q.delete(); obs_q.delete();
      tag_enable = 1'b0;
      step(1'b1, 16'h4321, 1'b1, 1'b1, acc);
`ifdef ACT_TIMEOUT_EN
      while (obs_q.size() == 0 && cyc < TIMEOUT + SETTLE + 40) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, acc);
         cyc++;
      end
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("[TB] FAIL timeout_emit got %0d results want 1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o !== {16'h0000, 16'h4321, 1'b1}) begin
            errors++; $display("[TB] FAIL timeout_result got val=%h sum=%h err=%b want 0000 4321 1", o.value, o.sum, o.err);
         end
      end
      exp_q.delete(); obs_q.delete();
      tag_enable = 1'b1; tag_delay = 1;
      step(1'b1, 16'h0123, 1'b0, 1'b1, acc);
      cyc = 0;
      while (obs_q.size() == 0 && cyc < 100) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, acc);
         cyc++;
      end
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {unit_value(16'h0123, 1'b0), 16'h0123, 1'b0}) begin
         errors++; $display("[TB] FAIL timeout_recover got %0d results want 1 normal result", obs_q.size());
      end
`else
      while (cyc < 200) begin
         step(1'b0, 16'h0, 1'b0, 1'b1, acc);
         checks++;
         if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stuck_wait cycle %0d got busy=%b out_valid=%b want 1 0", cyc, busy, out_valid);
         end
         cyc++;
      end
      test_reset();
      tag_enable = 1'b1;
`endif
   endtask

   task automatic test_reset_mid();
      bit acc;
      int accepted = 0;
      exp_q.delete(); obs_q.delete();
      tag_enable = 1'b1; tag_delay = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b1, acc);
         if (acc) accepted++;
      end
      checks++;
      if (accepted != 4 || busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_setup got accepted=%0d busy=%b want 4 1", accepted, busy);
      end
      reset = 1'b1;
      step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      checks++;
      if ({busy, in_ready, out_valid, act_sum} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
         errors++;
         $display("[TB] FAIL midreset_state got busy=%b in_ready=%b out_valid=%b act_sum=%h want 0 1 0 0000",
                  busy, in_ready, out_valid, act_sum);
      end
      reset = 1'b0;
      repeat (30) step(1'b0, 16'h0, 1'b0, 1'b1, acc);
      checks++;
      if (obs_q.size() != 0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_discard got %0d results busy=%b want 0 0", obs_q.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_single(16'h0800, FUNC_SIGMOID, 2, 16'h2ECA);
      test_single(16'h0800, FUNC_TANH, 2, 16'h30BE);
      test_single(16'h1234, FUNC_SIGMOID, 6, unit_value(16'h1234, FUNC_SIGMOID));
      test_single(16'h8001, FUNC_TANH, 0, unit_value(16'h8001, FUNC_TANH));
      test_back_to_back();
      test_stream(8, 1'b1);
      test_stream(20, 1'b0);
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
